// File: rtl/bcnn_pkg.sv
// Shared definitions for the BCNN datapath: operand widths, fixed-point
// operand types and the batch-norm sequencing states.
package bcnn_pkg;

    localparam int DATA_W = 16;  // convolution accumulator, signed Q8.8
    localparam int COEF_W = 12;  // folded coefficients and result, signed Q4.8
    localparam int FRAC_W = 8;   // fractional bits common to every operand

    typedef logic signed [COEF_W-1:0] q48_t;
    typedef logic signed [DATA_W-1:0] q88_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } bn_state_t;

endpackage : bcnn_pkg

// File: rtl/batch_norm_q_sat.sv
// Narrows a signed sum to OUT_W bits.
// BATCH_NORM_SAT_EN defined   : clamp to the OUT_W signed range.
// BATCH_NORM_SAT_EN undefined : keep the low OUT_W bits (wrap-around).
module q_sat #(
    parameter int IN_W  = 21,
    parameter int OUT_W = 12
) (
    input  logic signed [IN_W-1:0]  val_i,
    output logic signed [OUT_W-1:0] sat_o
);

`ifdef BATCH_NORM_SAT_EN
    localparam logic signed [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

    logic fits;

    // The value fits when every bit above the result sign bit matches the sign.
    always_comb begin
        fits  = (val_i[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){val_i[IN_W-1]}});
        sat_o = val_i[OUT_W-1:0];
        if (!fits) begin
            sat_o = val_i[IN_W-1] ? MIN_V : MAX_V;
        end
    end
`else
    // Bits above the result width are discarded on purpose in wrap mode.
    logic unused_hi;
    assign unused_hi = ^val_i[IN_W-1:OUT_W];
    assign sat_o     = val_i[OUT_W-1:0];
`endif

endmodule : q_sat

// File: rtl/batch_norm.sv
// Per-channel batch normalization: out = data_in * theta + phi (Q4.8 result).
// Sequence IDLE -> MUL -> ADD -> DONE -> IDLE, one operation per 4 cycles.
// Overflow handling in the ADD stage is selected by BATCH_NORM_SAT_EN
// (clamp when defined, wrap-around otherwise).
module batch_norm #(
    parameter int DATA_W = bcnn_pkg::DATA_W,
    parameter int COEF_W = bcnn_pkg::COEF_W,
    parameter int FRAC_W = bcnn_pkg::FRAC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ready,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic signed [COEF_W-1:0] theta,
    input  logic signed [COEF_W-1:0] phi,
    output logic                     finish,
    output logic signed [COEF_W-1:0] out
);
    import bcnn_pkg::*;

    // state | meaning
    // IDLE  | waiting for ready; operands captured on the accepting edge
    // MUL   | full-width product of the captured operands is registered
    // ADD   | scaled product plus phi is narrowed and registered to out
    // DONE  | finish is high for this single cycle; back to IDLE next

    localparam int PROD_W = DATA_W + COEF_W;         // Q12.16 product
    localparam int SHR_W  = PROD_W - FRAC_W;         // Q12.8 after the shift
    localparam int SUM_W  = SHR_W + 1;               // one guard bit for the add

    bn_state_t                 state_q, state_d;
    logic signed [DATA_W-1:0]  data_q, data_d;
    logic signed [COEF_W-1:0]  theta_q, theta_d;
    logic signed [COEF_W-1:0]  phi_q, phi_d;
    logic signed [PROD_W-1:0]  prod_q, prod_d;
    logic signed [COEF_W-1:0]  out_q, out_d;
    logic                      finish_q, finish_d;

    logic signed [PROD_W-1:0]  data_ext, theta_ext, prod_mul;
    logic signed [SHR_W-1:0]   prod_shr;
    logic signed [SUM_W-1:0]   sum_w;
    logic signed [COEF_W-1:0]  sum_nar;
    logic                      unused_prod_lo;

    // Sign-extend both operands to the product width so the multiply is exact.
    always_comb begin
        data_ext  = {{COEF_W{data_q[DATA_W-1]}}, data_q};
        theta_ext = {{DATA_W{theta_q[COEF_W-1]}}, theta_q};
        prod_mul  = data_ext * theta_ext;
    end

    // Dropping the low FRAC_W bits of a two's-complement value is a floor shift.
    always_comb begin
        prod_shr = prod_q[PROD_W-1:FRAC_W];
        sum_w    = {prod_shr[SHR_W-1], prod_shr}
                 + {{(SUM_W-COEF_W){phi_q[COEF_W-1]}}, phi_q};
    end

    assign unused_prod_lo = ^prod_q[FRAC_W-1:0];

    q_sat #(
        .IN_W  (SUM_W),
        .OUT_W (COEF_W)
    ) u_q_sat (
        .val_i (sum_w),
        .sat_o (sum_nar)
    );

    // Next-state and datapath-update decode; registers hold unless a state acts.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        theta_d  = theta_q;
        phi_d    = phi_q;
        prod_d   = prod_q;
        out_d    = out_q;
        finish_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ready) begin
                    data_d  = data_in;
                    theta_d = theta;
                    phi_d   = phi;
                    state_d = MUL;
                end
            end
            MUL: begin
                prod_d  = prod_mul;
                state_d = ADD;
            end
            ADD: begin
                out_d    = sum_nar;
                finish_d = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, product and result registers, all cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q   <= '0;
            theta_q  <= '0;
            phi_q    <= '0;
            prod_q   <= '0;
            out_q    <= '0;
            finish_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            theta_q  <= theta_d;
            phi_q    <= phi_d;
            prod_q   <= prod_d;
            out_q    <= out_d;
            finish_q <= finish_d;
        end
    end

    assign finish = finish_q;
    assign out    = out_q;

endmodule : batch_norm

// File: tb/tb_batch_norm.sv
// Directed bench for batch_norm with hand-computed expected results.
module tb_batch_norm;

    logic        clk;
    logic        rst;
    logic        ready;
    logic [15:0] data_in;
    logic [11:0] theta;
    logic [11:0] phi;
    logic        finish;
    logic [11:0] out;

    int n_assert = 0;
    int n_fail   = 0;

    batch_norm dut (
        .clk     (clk),
        .rst     (rst),
        .ready   (ready),
        .data_in (data_in),
        .theta   (theta),
        .phi     (phi),
        .finish  (finish),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start one operation and check finish/out through its full 4-cycle window.
    task automatic run_op(input logic [15:0] d, input logic [11:0] t, input logic [11:0] p,
                          input logic [11:0] exp_out, input string tag);
        @(negedge clk);
        ready = 1'b1; data_in = d; theta = t; phi = p;
        @(posedge clk); #1;
        ready = 1'b0; data_in = 16'hA5A5; theta = 12'h5A5; phi = 12'h3C3;
        @(negedge clk);
        check({tag, " finish k+0"}, finish, 0);
        @(negedge clk);
        check({tag, " finish k+1"}, finish, 0);
        @(negedge clk);
        check({tag, " finish k+2"}, finish, 1);
        check({tag, " out"}, out, exp_out);
        @(negedge clk);
        check({tag, " finish k+3"}, finish, 0);
        check({tag, " out held"}, out, exp_out);
    endtask

    int n_fin;
    int fin_a;
    int fin_b;

    initial begin
        rst = 1'b0; ready = 1'b0; data_in = '0; theta = '0; phi = '0;
        #2;
        check("reset finish", finish, 0);
        check("reset out", out, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        run_op(16'h0100, 12'h100, 12'h000, 12'h100, "unit");
        run_op(16'h0200, 12'h080, 12'h040, 12'h140, "half_plus_q");
        run_op(16'hFF00, 12'h200, 12'h080, 12'hE80, "neg");
        run_op(16'hFFFF, 12'h080, 12'h000, 12'hFFF, "floor");
        run_op(16'h0000, 12'h123, 12'h7FF, 12'h7FF, "phi_max");
`ifdef BATCH_NORM_SAT_EN
        run_op(16'h7F00, 12'h100, 12'h000, 12'h7FF, "ovf_pos");
        run_op(16'h8000, 12'h100, 12'h000, 12'h800, "ovf_neg");
`else
        run_op(16'h7F00, 12'h100, 12'h000, 12'hF00, "ovf_pos");
        run_op(16'h8000, 12'h100, 12'h000, 12'h000, "ovf_neg");
`endif

        // Busy: a second ready pulse while in MUL must be ignored.
        run_op(16'hFF00, 12'h200, 12'h080, 12'hE80, "pre_busy");
        @(negedge clk);
        ready = 1'b1; data_in = 16'h0200; theta = 12'h080; phi = 12'h040;
        @(posedge clk); #1;
        ready = 1'b0;
        @(negedge clk);
        ready = 1'b1; data_in = 16'h0100; theta = 12'h100; phi = 12'h000;
        @(posedge clk); #1;
        ready = 1'b0;
        n_fin = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (finish) n_fin++;
        end
        check("busy finish count", n_fin, 1);
        check("busy out", out, 12'h140);

        // ready held high for 8 cycles: samples at edges 1 and 5.
        @(negedge clk);
        ready = 1'b1; data_in = 16'h0100; theta = 12'h100; phi = 12'h001;
        n_fin = 0; fin_a = -1; fin_b = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 8) ready = 1'b0;
            if (finish) begin
                n_fin++;
                if (fin_a < 0) fin_a = i;
                else fin_b = i;
            end
        end
        check("held finish count", n_fin, 2);
        check("held first finish", fin_a, 3);
        check("held second finish", fin_b, 7);
        check("held out", out, 12'h101);

        // Reset while in MUL aborts the operation.
        @(negedge clk);
        ready = 1'b1; data_in = 16'h0200; theta = 12'h080; phi = 12'h000;
        @(posedge clk); #1;
        ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid reset finish", finish, 0);
        check("mid reset out", out, 0);
        @(negedge clk);
        rst = 1'b1;
        n_fin = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (finish) n_fin++;
        end
        check("post reset no finish", n_fin, 0);
        check("post reset out", out, 0);
        run_op(16'hFF00, 12'h200, 12'h080, 12'hE80, "recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_batch_norm
